// File: rtl/hazard_stall_unit.sv
// Load-use / branch-wait hazard controller driving ID noop and front-end enables.
// Optional statistics counters built only when HAZARD_STATS_EN is defined.
module hazard_stall_unit #(
  parameter int BR_TIMEOUT = 3,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Instruction_ID,
  input  logic              MemRead_EX,
  input  logic [4:0]        Rt_EX,
  input  logic              Branch_ID,
  input  logic              Jump_control_ID,
  input  logic              Branch_resolved,
  input  logic              Branch_taken,
  output logic              ID_Control_Noop,
  output logic              PCWrite,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic [STAT_W-1:0] Stall_cycles,
  output logic [STAT_W-1:0] Load_stalls
);

  typedef enum logic {RUN, BR_WAIT} state_t;

  typedef struct packed {
    logic noop;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
  } ctl_t;

  localparam ctl_t CTL_RST   = '{noop: 1'b1, pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1};
  localparam ctl_t CTL_GO    = '{noop: 1'b0, pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0};
  localparam ctl_t CTL_HOLD  = '{noop: 1'b1, pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0};
  localparam ctl_t CTL_JUMP  = '{noop: 1'b0, pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1};
  localparam ctl_t CTL_TAKEN = '{noop: 1'b1, pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1};
  localparam logic [3:0] WLAST = 4'(BR_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  ctl_t       ctl;
  logic       load_taken;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       uses_rt, load_use;

  assign op      = Instruction_ID[31:26];
  assign rs      = Instruction_ID[25:21];
  assign rt      = Instruction_ID[20:16];
  assign uses_rt = (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100);
  assign load_use = MemRead_EX && (Rt_EX != 5'd0) &&
                    ((Rt_EX == rs) || (uses_rt && (Rt_EX == rt)));

  always_comb begin
    ctl        = CTL_GO;
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    load_taken = 1'b0;
    if (reset) begin
      ctl = CTL_RST;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            ctl        = CTL_HOLD;
            load_taken = 1'b1;
          end else if (Branch_ID) begin
            state_nxt = BR_WAIT;
            wcnt_nxt  = 4'd0;
          end else if (Jump_control_ID) begin
            ctl = CTL_JUMP;
          end
        end
        BR_WAIT: begin
          ctl = CTL_HOLD;
          if (Branch_resolved) begin
            ctl       = Branch_taken ? CTL_TAKEN : CTL_GO;
            state_nxt = RUN;
          end else if (wcnt == WLAST) begin
            // No outcome arrived in time: release as not-taken so the front end cannot hang.
            ctl       = CTL_GO;
            state_nxt = RUN;
          end else begin
            wcnt_nxt = wcnt + 4'd1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  assign ID_Control_Noop = ctl.noop;
  assign PCWrite         = ctl.pc_write;
  assign IFID_Write      = ctl.ifid_write;
  assign IFID_Flush      = ctl.ifid_flush;

  logic unused_bits;
  assign unused_bits = ^Instruction_ID[15:0];

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt, load_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      load_cnt  <= '0;
    end else begin
      if (!ctl.pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (load_taken && load_cnt != '1)     load_cnt  <= load_cnt + 1'b1;
    end
  end

  assign Stall_cycles = stall_cnt;
  assign Load_stalls  = load_cnt;
`else
  logic unused_stat;
  assign unused_stat  = load_taken;
  assign Stall_cycles = '0;
  assign Load_stalls  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboarded directed bench for hazard_stall_unit; control outputs packed as
// {Noop, PCWrite, IFID_Write, IFID_Flush}. Stats checks follow HAZARD_STATS_EN.
module tb_hazard_stall_unit;
  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       Instruction_ID;
  logic              MemRead_EX;
  logic [4:0]        Rt_EX;
  logic              Branch_ID, Jump_control_ID, Branch_resolved, Branch_taken;
  logic              ID_Control_Noop, PCWrite, IFID_Write, IFID_Flush;
  logic [STAT_W-1:0] Stall_cycles, Load_stalls;

  int errs = 0;
  int checks = 0;

  logic [3:0] expq[$];
  string      tagq[$];

  localparam logic [3:0] RST = 4'b1001, GO = 4'b0110, HOLD = 4'b1000,
                         JMP = 4'b0111, TKN = 4'b1101;
  localparam logic [31:0] ADD_R8  = 32'h01095020;
  localparam logic [31:0] LW_RT8  = {6'b100011, 5'd1, 5'd8, 16'h0004};
  localparam logic [31:0] ADD_RT8 = {6'b000000, 5'd1, 5'd8, 5'd3, 11'h020};

  hazard_stall_unit #(.BR_TIMEOUT(3), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset), .Instruction_ID(Instruction_ID),
    .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .Branch_ID(Branch_ID),
    .Jump_control_ID(Jump_control_ID), .Branch_resolved(Branch_resolved),
    .Branch_taken(Branch_taken), .ID_Control_Noop(ID_Control_Noop),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .Stall_cycles(Stall_cycles), .Load_stalls(Load_stalls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Instruction_ID  = 32'h0;
    MemRead_EX      = 1'b0;
    Rt_EX           = 5'd0;
    Branch_ID       = 1'b0;
    Jump_control_ID = 1'b0;
    Branch_resolved = 1'b0;
    Branch_taken    = 1'b0;
  endtask

  // Inputs are already applied; queue the expectation, compare at the negedge, advance a cycle.
  task automatic step(input string tag, input logic [3:0] exp);
    logic [3:0] got;
    expq.push_back(exp);
    tagq.push_back(tag);
    @(negedge clk);
    got = {ID_Control_Noop, PCWrite, IFID_Write, IFID_Flush};
    if (expq.size() == 0) begin
      errs++;
      $display("FAIL scoreboard_empty: got %h expected entry", got);
    end else
      chk(tagq.pop_front(), {28'h0, got}, {28'h0, expq.pop_front()});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    step("rst0", RST);
    step("rst1", RST);
    reset = 1'b0;
    step("post_rst", GO);

    // load-use via rs, then one bubble only
    MemRead_EX = 1'b1; Rt_EX = 5'd8; Instruction_ID = ADD_R8;
    step("lu_rs", HOLD);
    MemRead_EX = 1'b0;
    step("lu_clear", GO);
    MemRead_EX = 1'b1; Rt_EX = 5'd0;
    step("lu_r0", GO);
    Rt_EX = 5'd8; Instruction_ID = LW_RT8;
    step("lu_lw_rt", GO);
    Instruction_ID = ADD_RT8;
    step("lu_add_rt", HOLD);
    idle();

    // branch taken on 2nd wait cycle; ignored inputs in the 1st
    Branch_ID = 1'b1;
    step("bt_id", GO);
    idle();
    MemRead_EX = 1'b1; Rt_EX = 5'd8; Instruction_ID = ADD_R8;
    Jump_control_ID = 1'b1; Branch_taken = 1'b1;
    step("bt_w1", HOLD);
    idle();
    Branch_resolved = 1'b1; Branch_taken = 1'b1;
    step("bt_res", TKN);
    idle();
    Branch_resolved = 1'b1; Branch_taken = 1'b1;
    step("run_ign_res", GO);
    idle();

    // branch not taken on 1st wait cycle
    Branch_ID = 1'b1;
    step("bn_id", GO);
    idle();
    Branch_resolved = 1'b1;
    step("bn_res", GO);
    idle();
    step("bn_run", GO);

    // timeout exit on the 3rd wait cycle
    Branch_ID = 1'b1;
    step("to_id", GO);
    idle();
    step("to_w1", HOLD);
    step("to_w2", HOLD);
    step("to_exit", GO);
    Jump_control_ID = 1'b1;
    step("to_run_jmp", JMP);
    idle();
    step("jmp_once", GO);

    // jump with simultaneous load-use: stall first
    Jump_control_ID = 1'b1; MemRead_EX = 1'b1; Rt_EX = 5'd8; Instruction_ID = ADD_R8;
    step("jl_stall", HOLD);
    MemRead_EX = 1'b0;
    step("jl_jump", JMP);
    idle();

    // branch beats jump
    Branch_ID = 1'b1; Jump_control_ID = 1'b1;
    step("bj_id", GO);
    idle();
    step("bj_wait", HOLD);
    Branch_resolved = 1'b1;
    step("bj_res", GO);
    idle();

    // reset while waiting on a branch
    Branch_ID = 1'b1;
    step("rw_id", GO);
    idle();
    step("rw_w1", HOLD);
    reset = 1'b1;
    step("rw_rst", RST);
    reset = 1'b0;
    step("rw_run", GO);

`ifdef HAZARD_STATS_EN
    reset = 1'b1;
    step("st_rst", RST);
    reset = 1'b0;
    chk("st_zero_stall", 32'(Stall_cycles), 32'd0);
    MemRead_EX = 1'b1; Rt_EX = 5'd8; Instruction_ID = ADD_R8;
    step("st_lu1", HOLD);
    MemRead_EX = 1'b0;
    step("st_c1", GO);
    MemRead_EX = 1'b1;
    step("st_lu2", HOLD);
    idle();
    step("st_c2", GO);
    Branch_ID = 1'b1;
    step("st_br", GO);
    idle();
    step("st_w1", HOLD);
    step("st_w2", HOLD);
    Branch_resolved = 1'b1;
    step("st_res", GO);
    idle();
    chk("st_stall_cycles", 32'(Stall_cycles), 32'd4);
    chk("st_load_stalls", 32'(Load_stalls), 32'd2);
    Branch_ID = 1'b1;
    step("st_br2", GO);
    idle();
    step("st_w3", HOLD);
    reset = 1'b1;
    step("st_rst2", RST);
    reset = 1'b0;
    chk("st_clr_stall", 32'(Stall_cycles), 32'd0);
    chk("st_clr_load", 32'(Load_stalls), 32'd0);
    step("st_run", GO);
`else
    chk("stat_tied_stall", 32'(Stall_cycles), 32'd0);
    chk("stat_tied_load", 32'(Load_stalls), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
